hex_seg7_writer: RTL and testbench

HEX_SEG7_WRITER -- requirements
Module: hex_seg7_writer

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/hex7seg_enc.sv | 12 +
 rtl/hex_seg7_writer.sv | 135 +++++++++++++
 tb/tb_hex_seg7_writer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the hex-to-7-segment display writer.
// Segment bit order is {g,f,e,d,c,b,a}; a 1 means the segment is lit.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Entry n is the pattern for hex digit n (entry 0 is the rightmost slice)
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational hex nibble to 7-segment pattern decoder.
// Pure table lookup; active-high segments.
module hex7seg_enc
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_TABLE[i_hex];

endmodule

// File: rtl/hex_seg7_writer.sv
// Writes NDIGITS decoded hex digits into a display register bank,
// one register per cycle, with optional leading-zero blanking.
module hex_seg7_writer
    import seg7_pkg::*;
#(
    parameter int NDIGITS = 6
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Start,
    input  logic [4*NDIGITS-1:0]   Value,
    input  logic                   Blank,
    output logic [6:0]             Data,
    output logic [2:0]             Addr,
    output logic                   Sel,
    output logic                   Busy,
    output logic                   Done
);

    localparam int         VW   = 4 * NDIGITS;
    localparam logic [2:0] LAST = 3'(NDIGITS - 1);

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [VW-1:0]   r_val;
    logic            r_blank;
    logic [6:0]      r_data;
    logic [2:0]      r_addr;
    logic            r_sel;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_n;
    logic [2:0]      w_cnt_n;
    logic [VW-1:0]   w_val_n;
    logic            w_blank_n;
    logic [3:0]      w_digit;
    logic [2:0]      w_msd;
    logic            w_blk;
    logic [6:0]      w_seg;
    logic            w_wr_n;

    // Next-state logic: latch on Start in IDLE, step the digit counter in WRITE
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_val_n   = r_val;
        w_blank_n = r_blank;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_n = S_WRITE;
                    w_cnt_n   = 3'd0;
                    w_val_n   = Value;
                    w_blank_n = Blank;
                end
            end
            S_WRITE: begin
                if (r_cnt == LAST) begin
                    w_state_n = S_FINISH;
                    w_cnt_n   = 3'd0;
                end else begin
                    w_cnt_n = r_cnt + 3'd1;
                end
            end
            S_FINISH: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Select the digit being written next and find the leading nonzero digit
    always_comb begin
        w_digit = 4'h0;
        w_msd   = 3'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w_cnt_n == 3'(i)) begin
                w_digit = w_val_n[4*i +: 4];
            end
            if (w_val_n[4*i +: 4] != 4'h0) begin
                w_msd = 3'(i);
            end
        end
    end

    assign w_blk  = w_blank_n && (w_cnt_n > w_msd);
    assign w_wr_n = (w_state_n == S_WRITE);

    hex7seg_enc u_enc (
        .i_hex (w_digit),
        .o_seg (w_seg)
    );

    // FSM state, digit counter and latched transaction operands
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_val   <= '0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_val   <= w_val_n;
            r_blank <= w_blank_n;
        end
    end

    // Registered outputs computed from the upcoming state
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_data <= 7'h00;
            r_addr <= 3'd0;
            r_sel  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sel  <= w_wr_n;
            r_addr <= w_wr_n ? w_cnt_n : 3'd0;
            r_data <= !w_wr_n ? 7'h00 : (w_blk ? SEG7_BLANK : w_seg);
            r_busy <= (w_state_n != S_IDLE);
            r_done <= (w_state_n == S_FINISH);
        end
    end

    assign Data = r_data;
    assign Addr = r_addr;
    assign Sel  = r_sel;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_hex_seg7_writer.sv
// Randomized bench for hex_seg7_writer (6-digit and 4-digit instances)
// against a digit-arithmetic reference model.
module tb_hex_seg7_writer;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start6 = 1'b0;
    logic        Start4 = 1'b0;
    logic        Blank = 1'b0;
    logic [23:0] Value6 = '0;
    logic [15:0] Value4 = '0;

    logic [6:0]  Data6, Data4;
    logic [2:0]  Addr6, Addr4;
    logic        Sel6, Sel4, Busy6, Busy4, Done6, Done4;

    int n_checks = 0;
    int n_pass   = 0;
    bit use4     = 1'b0;

    logic [6:0] d_o;
    logic [2:0] a_o;
    logic       s_o, b_o, f_o;

    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    hex_seg7_writer #(.NDIGITS(6)) u_dut6 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start6),
        .Value  (Value6),
        .Blank  (Blank),
        .Data   (Data6),
        .Addr   (Addr6),
        .Sel    (Sel6),
        .Busy   (Busy6),
        .Done   (Done6)
    );

    hex_seg7_writer #(.NDIGITS(4)) u_dut4 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start4),
        .Value  (Value4),
        .Blank  (Blank),
        .Data   (Data4),
        .Addr   (Addr4),
        .Sel    (Sel4),
        .Busy   (Busy4),
        .Done   (Done4)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        d_o = use4 ? Data4 : Data6;
        a_o = use4 ? Addr4 : Addr6;
        s_o = use4 ? Sel4  : Sel6;
        b_o = use4 ? Busy4 : Busy6;
        f_o = use4 ? Done4 : Done6;
    end

    // Expected pattern at position i: blank when everything from i upward is zero
    function automatic logic [6:0] model(input logic [31:0] v, input bit b,
                                         input int i);
        logic [31:0] upper;
        logic [3:0]  dig;
        upper = v >> (4 * i);
        dig   = upper[3:0];
        if (b && i > 0 && upper == 32'd0) return 7'h00;
        return SEG[dig];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic set_start(input bit s, input logic [31:0] v, input bit b);
        if (use4) Start4 = s;
        else Start6 = s;
        Value6 = v[23:0];
        Value4 = v[15:0];
        Blank  = b;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"},  32'(s_o), 0);
        check({tag, "_busy"}, 32'(b_o), 0);
        check({tag, "_done"}, 32'(f_o), 0);
        check({tag, "_data"}, 32'(d_o), 0);
        check({tag, "_addr"}, 32'(a_o), 0);
    endtask

    // One transaction; poke re-asserts Start in that write cycle, abort_at resets
    task automatic txn(input logic [31:0] v, input bit b, input int poke,
                       input int abort_at);
        int nd;
        logic [31:0] junk;
        nd = use4 ? 4 : 6;
        @(negedge Clock);
        set_start(1'b1, v, b);
        @(posedge Clock);
        #1;
        junk = $urandom;
        set_start(1'b0, junk, junk[31]);
        for (int i = 0; i < nd; i++) begin
            check("wr_sel",  32'(s_o), 1);
            check("wr_addr", 32'(a_o), 32'(i));
            check("wr_data", 32'(d_o), 32'(model(v, b, i)));
            check("wr_busy", 32'(b_o), 1);
            check("wr_done", 32'(f_o), 0);
            if (i == abort_at) begin
                Resetn = 1'b0;
                @(posedge Clock);
                #1;
                Resetn = 1'b1;
                check_idle("abort");
                for (int k = 0; k < nd + 2; k++) begin
                    @(posedge Clock);
                    #1;
                    check("abort_nodone", 32'(f_o), 0);
                    check("abort_nosel",  32'(s_o), 0);
                end
                return;
            end
            set_start(i == poke, ~v, ~b);
            @(posedge Clock);
            #1;
        end
        junk = $urandom;
        set_start(junk[0], ~v, b);
        check("fin_sel",  32'(s_o), 0);
        check("fin_done", 32'(f_o), 1);
        check("fin_busy", 32'(b_o), 1);
        check("fin_data", 32'(d_o), 0);
        check("fin_addr", 32'(a_o), 0);
        @(posedge Clock);
        #1;
        set_start(1'b0, junk, 1'b0);
        check_idle("post");
        @(posedge Clock);
        #1;
        check_idle("post2");
    endtask

    initial begin
        logic [31:0] r;
        int p;
        repeat (2) @(posedge Clock);
        #1;
        use4 = 1'b0;
        check_idle("rst6");
        use4 = 1'b1;
        check_idle("rst4");
        use4 = 1'b0;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        txn(32'h012345, 1'b0, -1, -1);
        txn(32'h0000A0, 1'b1, -1, -1);
        txn(32'h000000, 1'b1, -1, -1);
        txn(32'h00F00D, 1'b1, -1, -1);
        txn(32'h9ABCDE, 1'b0, 1, -1);
        txn(32'h012345, 1'b0, -1, 3);
        txn(32'h0C0FFE, 1'b1, -1, -1);

        // Reset wins over a simultaneous Start
        set_start(1'b1, 32'h123456, 1'b0);
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        set_start(1'b0, 32'h0, 1'b0);
        Resetn = 1'b1;
        check_idle("rst_prio");

        for (int n = 0; n < 24; n++) begin
            r = $urandom;
            r = r >> ($urandom_range(0, 6) * 4);
            p = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 5)) : -1;
            txn(r & 32'hFFFFFF, 1'($urandom), p, -1);
        end

        use4 = 1'b1;
        txn(32'hBEEF, 1'b0, -1, -1);
        txn(32'h00B0, 1'b1, -1, -1);
        txn(32'h0000, 1'b0, 2, -1);
        for (int n = 0; n < 10; n++) begin
            r = $urandom;
            r = r >> ($urandom_range(0, 4) * 4);
            txn(r & 32'hFFFF, 1'($urandom), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
